// File: rtl/stack_pkg.sv
// Shared opcode constants, FSM state encoding and program-word layout for the stack sequencer.
// The program word packs the 3-bit opcode above the operand, matching the program buffer layout.
package stack_pkg;

    localparam int DATA_W = 16;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd4;
    localparam logic [2:0] OP_MUL  = 3'd5;
    localparam logic [2:0] OP_PUSH = 3'd6;
    localparam logic [2:0] OP_POP  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_GAP   = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    typedef struct packed {
        logic [2:0]        op;
        logic [DATA_W-1:0] data;
    } prog_word_t;

    function automatic logic is_push(input logic [2:0] op);
        return op == OP_PUSH;
    endfunction

endpackage

// File: rtl/stack_sequencer_if.sv
// Host program-load/control signals plus the opcode/operand link to the stack ALU.
// master = host/stack side, slave = sequencer.
interface stack_sequencer_if #(
    parameter int N = 16
);
    logic         prog_valid;
    logic         prog_ready;
    logic [2:0]   prog_op;
    logic [N-1:0] prog_data;
    logic         prog_clear;
    logic         start;
    logic         busy;
    logic         done;
    logic         error;
    logic [N-1:0] result;
    logic [2:0]   stk_opcode;
    logic [N-1:0] stk_in;
    logic [N-1:0] stk_out;
    logic         stk_overflow;

    modport master (
        output prog_valid, prog_op, prog_data, prog_clear, start, stk_out, stk_overflow,
        input  prog_ready, busy, done, error, result, stk_opcode, stk_in
    );

    modport slave (
        input  prog_valid, prog_op, prog_data, prog_clear, start, stk_out, stk_overflow,
        output prog_ready, busy, done, error, result, stk_opcode, stk_in
    );
endinterface

// File: rtl/stack_prog_mem.sv
// Program buffer: DEPTH x W register file, one synchronous write port, one async read port.
// Read data follows rd_addr combinationally; no backpressure, writes land at the next clock edge.
module stack_prog_mem #(
    parameter int  DEPTH = 16,
    parameter int  W     = 19,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_dat,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_dat
);

    logic [W-1:0] mem_q [DEPTH];

    // Contents are qualified by the write pointer in the sequencer, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem_q[rd_addr];

endmodule

// File: rtl/stack_sequencer.sv
// Replays a buffered RPN program into the stack ALU, one instruction then one NOP gap per step.
// Outputs registered (k instructions -> 2k cycles start-to-done); program loads only accepted in IDLE.
module stack_sequencer
    import stack_pkg::*;
#(
    parameter int N     = DATA_W,
    parameter int DEPTH = 16,
    parameter int PW    = $clog2(DEPTH) + 1
) (
    input logic               clk,
    input logic               rst_n,
    stack_sequencer_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);

    state_t        state_q, state_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] pc_q, pc_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic [N-1:0]  result_q, result_d;
    logic [2:0]    stk_opcode_q, stk_opcode_d;
    logic [N-1:0]  stk_in_q, stk_in_d;

    logic          full;
    logic          wr_en;
    logic [N+2:0]  rd_word;
    logic [2:0]    rd_op;
    logic [N-1:0]  rd_data;

    assign full  = (wptr_q == PW'(DEPTH));
    // start and prog_clear take priority over a load offered in the same cycle.
    assign bus.prog_ready = (state_q == S_IDLE) && !full && !bus.start && !bus.prog_clear;
    assign wr_en = bus.prog_valid && bus.prog_ready;

    stack_prog_mem #(
        .DEPTH (DEPTH),
        .W     (N + 3)
    ) u_prog_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wptr_q[AW-1:0]),
        .wr_dat  ({bus.prog_op, bus.prog_data}),
        .rd_addr (pc_d[AW-1:0]),
        .rd_dat  (rd_word)
    );

    assign rd_op   = rd_word[N+2:N];
    assign rd_data = rd_word[N-1:0];

    always_comb begin
        state_d  = state_q;
        wptr_d   = wptr_q;
        pc_d     = pc_q;
        result_d = result_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.prog_clear) begin
                    wptr_d = '0;
                end else if (bus.start) begin
                    pc_d    = '0;
                    state_d = (wptr_q != '0) ? S_ISSUE : S_DONE;
                end else if (wr_en) begin
                    wptr_d = wptr_q + 1'b1;
                end
            end
            S_ISSUE: begin
                state_d = S_GAP;
            end
            S_GAP: begin
                // The stack has consumed the issued instruction by now, so stk_out is valid.
                if (bus.stk_overflow) begin
                    state_d = S_ERR;
                end else if (pc_q == wptr_q - 1'b1) begin
                    result_d = bus.stk_out;
                    state_d  = S_DONE;
                end else begin
                    pc_d    = pc_q + 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                if (bus.prog_clear) begin
                    wptr_d  = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flag and stack-port outputs are decoded from the next state so they align with state_q.
        busy_d       = (state_d == S_ISSUE) || (state_d == S_GAP);
        done_d       = (state_d == S_DONE);
        error_d      = (state_d == S_ERR);
        stk_opcode_d = (state_d == S_ISSUE) ? rd_op : OP_NOP;
        stk_in_d     = ((state_d == S_ISSUE) && is_push(rd_op)) ? rd_data : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            wptr_q       <= '0;
            pc_q         <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            result_q     <= '0;
            stk_opcode_q <= OP_NOP;
            stk_in_q     <= '0;
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            pc_q         <= pc_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            result_q     <= result_d;
            stk_opcode_q <= stk_opcode_d;
            stk_in_q     <= stk_in_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;
    assign bus.result     = result_q;
    assign bus.stk_opcode = stk_opcode_q;
    assign bus.stk_in     = stk_in_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer with a behavioural stack ALU that executes on opcode change.
module tb_stack_sequencer;
    import stack_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    stack_sequencer_if #(.N(16)) bus ();

    stack_sequencer #(
        .N     (16),
        .DEPTH (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural stack: acts only when the opcode differs from the previous cycle's opcode.
    logic [15:0] stk_mem [32];
    int          sp      = 0;
    logic [2:0]  prev_op = 3'd0;
    logic        ovf_force = 1'b0;

    always @(posedge clk) begin
        if (bus.stk_opcode != prev_op) begin
            case (bus.stk_opcode)
                OP_PUSH: if (sp < 32) begin
                    stk_mem[sp] <= bus.stk_in;
                    sp <= sp + 1;
                end
                OP_POP: if (sp > 0) sp <= sp - 1;
                OP_ADD: if (sp > 1) begin
                    stk_mem[sp-2] <= stk_mem[sp-2] + stk_mem[sp-1];
                    sp <= sp - 1;
                end
                OP_MUL: if (sp > 1) begin
                    stk_mem[sp-2] <= stk_mem[sp-2] * stk_mem[sp-1];
                    sp <= sp - 1;
                end
                default: ;
            endcase
        end
        prev_op <= bus.stk_opcode;
    end

    assign bus.stk_out      = (sp > 0) ? stk_mem[sp-1] : 16'd0;
    assign bus.stk_overflow = ovf_force;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    prog_word_t prog [16];
    int         nprog = 0;

    task automatic load_prog();
        @(negedge clk);
        bus.prog_clear = 1'b1;
        @(negedge clk);
        bus.prog_clear = 1'b0;
        for (int i = 0; i < nprog; i++) begin
            bus.prog_valid = 1'b1;
            bus.prog_op    = prog[i].op;
            bus.prog_data  = prog[i].data;
            #1;
            chk($sformatf("load_rdy[%0d]", i), {31'd0, bus.prog_ready}, 32'd1);
            @(negedge clk);
        end
        bus.prog_valid = 1'b0;
    endtask

    // Starts the buffered program and checks every cycle up to and including the done pulse.
    task automatic run_check(input int k, input logic [15:0] exp_res);
        logic [2:0]  exp_op;
        logic [15:0] exp_in;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int j = 0; j <= 2 * k; j++) begin
            if (j > 0) @(negedge clk);
            exp_op = 3'd0;
            exp_in = 16'd0;
            if (j < 2 * k && j % 2 == 0) begin
                exp_op = prog[j/2].op;
                exp_in = (prog[j/2].op == OP_PUSH) ? prog[j/2].data : 16'd0;
            end
            chk($sformatf("op[%0d]", j),   {29'd0, bus.stk_opcode}, {29'd0, exp_op});
            chk($sformatf("in[%0d]", j),   {16'd0, bus.stk_in},     {16'd0, exp_in});
            chk($sformatf("done[%0d]", j), {31'd0, bus.done},       {31'd0, (j == 2 * k)});
            chk($sformatf("busy[%0d]", j), {31'd0, bus.busy},       {31'd0, (j < 2 * k)});
        end
        chk("result", {16'd0, bus.result}, {16'd0, exp_res});
        @(negedge clk);
        chk("done_clr", {31'd0, bus.done}, 32'd0);
        chk("idle_rdy", {31'd0, bus.prog_ready}, {31'd0, (nprog < 16)});
    endtask

    initial begin
        int          sp0;
        logic        seen_done;
        logic [15:0] dummy;

        bus.prog_valid = 1'b0;
        bus.prog_op    = 3'd0;
        bus.prog_data  = 16'd0;
        bus.prog_clear = 1'b0;
        bus.start      = 1'b0;

        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy",  {31'd0, bus.busy},       32'd0);
        chk("rst_done",  {31'd0, bus.done},       32'd0);
        chk("rst_err",   {31'd0, bus.error},      32'd0);
        chk("rst_res",   {16'd0, bus.result},     32'd0);
        chk("rst_op",    {29'd0, bus.stk_opcode}, 32'd0);
        chk("rst_in",    {16'd0, bus.stk_in},     32'd0);
        chk("rst_rdy",   {31'd0, bus.prog_ready}, 32'd1);
        rst_n = 1'b1;

        // Full RPN program: 1 2 -30000 400 5 POP ADD MUL ADD -> 1 + 2*(-30000+400) = 0x18C1.
        nprog = 9;
        prog[0] = '{op: OP_PUSH, data: 16'd1};
        prog[1] = '{op: OP_PUSH, data: 16'd2};
        prog[2] = '{op: OP_PUSH, data: 16'h8AD0};
        prog[3] = '{op: OP_PUSH, data: 16'd400};
        prog[4] = '{op: OP_PUSH, data: 16'd5};
        prog[5] = '{op: OP_POP,  data: 16'h1234};
        prog[6] = '{op: OP_ADD,  data: 16'd0};
        prog[7] = '{op: OP_MUL,  data: 16'd0};
        prog[8] = '{op: OP_ADD,  data: 16'd0};
        load_prog();
        run_check(9, 16'h18C1);
        chk("res_model", {16'd0, bus.result}, {16'd0, bus.stk_out});

        // Back-to-back identical PUSHes must both reach the stack.
        nprog = 2;
        prog[0] = '{op: OP_PUSH, data: 16'd7};
        prog[1] = '{op: OP_PUSH, data: 16'd7};
        load_prog();
        sp0 = sp;
        run_check(2, 16'd7);
        chk("sp_adv2", sp, sp0 + 2);

        // Overflow during the third gap.
        nprog = 4;
        prog[0] = '{op: OP_PUSH, data: 16'd10};
        prog[1] = '{op: OP_PUSH, data: 16'd20};
        prog[2] = '{op: OP_PUSH, data: 16'd30};
        prog[3] = '{op: OP_PUSH, data: 16'd40};
        load_prog();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        seen_done = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus.done) seen_done = 1'b1;
        end
        chk("gap3_op",   {29'd0, bus.stk_opcode}, 32'd0);
        chk("gap3_busy", {31'd0, bus.busy},       32'd1);
        ovf_force = 1'b1;
        @(negedge clk);
        ovf_force = 1'b0;
        chk("err_set",  {31'd0, bus.error},      32'd1);
        chk("err_busy", {31'd0, bus.busy},       32'd0);
        chk("err_op",   {29'd0, bus.stk_opcode}, 32'd0);
        chk("err_res",  {16'd0, bus.result},     32'd7);
        chk("err_rdy",  {31'd0, bus.prog_ready}, 32'd0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen_done = 1'b1;
        end
        chk("err_no_done", {31'd0, seen_done},    32'd0);
        chk("err_hold",    {31'd0, bus.error},    32'd1);
        bus.prog_clear = 1'b1;
        @(negedge clk);
        bus.prog_clear = 1'b0;
        #1;
        chk("clr_err", {31'd0, bus.error},      32'd0);
        chk("clr_rdy", {31'd0, bus.prog_ready}, 32'd1);

        // Full buffer: a 17th word is refused and never executed.
        nprog = 16;
        for (int i = 0; i < 16; i++) prog[i] = '{op: OP_PUSH, data: 16'(100 + i)};
        load_prog();
        bus.prog_valid = 1'b1;
        bus.prog_op    = OP_PUSH;
        bus.prog_data  = 16'hDEAD;
        #1;
        chk("full_rdy", {31'd0, bus.prog_ready}, 32'd0);
        @(negedge clk);
        bus.prog_valid = 1'b0;
        run_check(16, 16'd115);

        // Empty buffer: done next cycle, nothing issued, result kept.
        nprog = 0;
        load_prog();
        run_check(0, 16'd115);

        // Reset while pc=2 is issuing.
        nprog = 4;
        for (int i = 0; i < 4; i++) prog[i] = '{op: OP_PUSH, data: 16'(1 + i)};
        load_prog();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_op", {29'd0, bus.stk_opcode}, {29'd0, OP_PUSH});
        dummy = bus.stk_in;
        chk("mid_in", {16'd0, dummy}, 32'd3);
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", {31'd0, bus.busy},       32'd0);
        chk("mrst_done", {31'd0, bus.done},       32'd0);
        chk("mrst_err",  {31'd0, bus.error},      32'd0);
        chk("mrst_res",  {16'd0, bus.result},     32'd0);
        chk("mrst_op",   {29'd0, bus.stk_opcode}, 32'd0);
        chk("mrst_in",   {16'd0, bus.stk_in},     32'd0);
        chk("mrst_rdy",  {31'd0, bus.prog_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        nprog = 0;
        run_check(0, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
